dual_slope_ctrl: RTL

- Conversion sequencer for the dual-slope voltmeter front end. It drives the analog control outputs (afe_sel_o, range_sel_o, afe_reset_o, ref_sign_o) and consumes the analog status inputs.
- Runs autozero, fixed-time integrate, then timed de-integrate against the reference.
- Packs the de-integrate count and status flags into a 32-bit result word with a one-cycle valid strobe.
- Sits directly upstream of the SPI slave: result_o feeds the SPI transmit word (di_i), and result_valid_o drives its write-enable path.

---
 rtl/dual_slope_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC conversion sequencer: autozero, fixed integrate, timed de-integrate,
// then a packed result word with a one-cycle valid strobe.
module dual_slope_ctrl #(
   parameter int CNT_W     = 24,
   parameter int T_AZ      = 1000,
   parameter int T_INT     = 10000,
   parameter int DEINT_MAX = 20000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic        cont_i,
   input  logic [2:0]  range_i,
   input  logic        comp_i,
   input  logic        sat_hi_i,
   input  logic        sat_lo_i,
   input  logic        ref_ok_i,
   output logic [1:0]  afe_sel_o,
   output logic [2:0]  range_sel_o,
   output logic        afe_reset_o,
   output logic        ref_sign_o,
   output logic        busy_o,
   output logic [31:0] result_o,
   output logic        result_valid_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AUTOZERO,
      S_INTEGRATE,
      S_DEINT,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] AZ_LAST    = CNT_W'(T_AZ - 1);
   localparam logic [CNT_W-1:0] INT_LAST   = CNT_W'(T_INT - 1);
   localparam logic [CNT_W-1:0] DEINT_LAST = CNT_W'(DEINT_MAX - 1);
   localparam logic [CNT_W-1:0] DEINT_FULL = CNT_W'(DEINT_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next, res_cnt;
   logic             pol, pol_next;
   logic             ovr, ovr_next;
   logic             sat_hi_seen, sat_hi_next;
   logic             sat_lo_seen, sat_lo_next;
   logic             ref_fail, ref_fail_next;
   logic [2:0]       range_next;
   logic [1:0]       sel_next;
   logic             afe_reset_next;
   logic [31:0]      result_next;

   logic [1:0] comp_sync, sat_hi_sync, sat_lo_sync, ref_ok_sync;
   logic       comp_s, sat_hi_s, sat_lo_s, ref_ok_s;

   // Analog status lines are asynchronous to clk_i; all decisions use the synchronised copies.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         comp_sync   <= '0;
         sat_hi_sync <= '0;
         sat_lo_sync <= '0;
         ref_ok_sync <= '0;
      end else begin
         comp_sync   <= {comp_sync[0], comp_i};
         sat_hi_sync <= {sat_hi_sync[0], sat_hi_i};
         sat_lo_sync <= {sat_lo_sync[0], sat_lo_i};
         ref_ok_sync <= {ref_ok_sync[0], ref_ok_i};
      end
   end

   assign comp_s   = comp_sync[1];
   assign sat_hi_s = sat_hi_sync[1];
   assign sat_lo_s = sat_lo_sync[1];
   assign ref_ok_s = ref_ok_sync[1];

   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      pol_next      = pol;
      ovr_next      = ovr;
      sat_hi_next   = sat_hi_seen;
      sat_lo_next   = sat_lo_seen;
      ref_fail_next = ref_fail;
      range_next    = range_sel_o;
      res_cnt       = '0;

      case (state)
         S_IDLE: begin
            if (start_i && !abort_i) begin
               range_next    = range_i;
               ovr_next      = 1'b0;
               sat_hi_next   = 1'b0;
               sat_lo_next   = 1'b0;
               ref_fail_next = 1'b0;
               pol_next      = 1'b0;
               cnt_next      = '0;
               if (ref_ok_s) begin
                  state_next = S_AUTOZERO;
               end else begin
                  ref_fail_next = 1'b1;
                  state_next    = S_DONE;
               end
            end
         end
         S_AUTOZERO: begin
            if (!ref_ok_s) begin
               ref_fail_next = 1'b1;
               state_next    = S_DONE;
            end else if (cnt == AZ_LAST) begin
               cnt_next   = '0;
               state_next = S_INTEGRATE;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         S_INTEGRATE: begin
            if (!ref_ok_s) begin
               ref_fail_next = 1'b1;
               state_next    = S_DONE;
            end else if (sat_hi_s || sat_lo_s) begin
               sat_hi_next = sat_hi_seen | sat_hi_s;
               sat_lo_next = sat_lo_seen | sat_lo_s;
               ovr_next    = 1'b1;
               state_next  = S_DONE;
            end else if (cnt == INT_LAST) begin
               pol_next   = comp_s;
               cnt_next   = '0;
               state_next = S_DEINT;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         S_DEINT: begin
            // Saturation while de-integrating is only recorded; the crossing still decides the exit.
            sat_hi_next = sat_hi_seen | sat_hi_s;
            sat_lo_next = sat_lo_seen | sat_lo_s;
            if (!ref_ok_s) begin
               ref_fail_next = 1'b1;
               res_cnt       = cnt;
               state_next    = S_DONE;
            end else if (comp_s != pol) begin
               res_cnt    = cnt + CNT_ONE;
               state_next = S_DONE;
            end else if (cnt == DEINT_LAST) begin
               ovr_next   = 1'b1;
               res_cnt    = DEINT_FULL;
               state_next = S_DONE;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         S_DONE: begin
            if (cont_i && ref_ok_s) begin
               range_next    = range_i;
               ovr_next      = 1'b0;
               sat_hi_next   = 1'b0;
               sat_lo_next   = 1'b0;
               ref_fail_next = 1'b0;
               pol_next      = 1'b0;
               cnt_next      = '0;
               state_next    = S_AUTOZERO;
            end else begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase

      if (abort_i && state != S_IDLE) begin
         state_next = S_IDLE;
         range_next = '0;
      end
   end

   // Output decode works on the next state so the registered outputs change with the state register.
   always_comb begin
      sel_next       = 2'b00;
      afe_reset_next = 1'b1;
      case (state_next)
         S_INTEGRATE: begin
            sel_next       = 2'b01;
            afe_reset_next = 1'b0;
         end
         S_DEINT: begin
            sel_next       = 2'b10;
            afe_reset_next = 1'b0;
         end
         default: begin
            sel_next       = 2'b00;
            afe_reset_next = 1'b1;
         end
      endcase
   end

   always_comb begin
      result_next            = '0;
      result_next[31:27]     = {ovr_next, sat_hi_next, sat_lo_next, ref_fail_next, pol_next};
      result_next[26:24]     = range_next;
      result_next[CNT_W-1:0] = res_cnt;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= S_IDLE;
         cnt            <= '0;
         pol            <= 1'b0;
         ovr            <= 1'b0;
         sat_hi_seen    <= 1'b0;
         sat_lo_seen    <= 1'b0;
         ref_fail       <= 1'b0;
         range_sel_o    <= 3'b000;
         afe_sel_o      <= 2'b00;
         afe_reset_o    <= 1'b1;
         ref_sign_o     <= 1'b0;
         busy_o         <= 1'b0;
         result_o       <= '0;
         result_valid_o <= 1'b0;
      end else begin
         state          <= state_next;
         cnt            <= cnt_next;
         pol            <= pol_next;
         ovr            <= ovr_next;
         sat_hi_seen    <= sat_hi_next;
         sat_lo_seen    <= sat_lo_next;
         ref_fail       <= ref_fail_next;
         range_sel_o    <= range_next;
         afe_sel_o      <= sel_next;
         afe_reset_o    <= afe_reset_next;
         ref_sign_o     <= (state_next == S_DEINT) ? pol_next : 1'b0;
         busy_o         <= (state_next != S_IDLE);
         result_valid_o <= (state_next == S_DONE);
         if (state_next == S_DONE) begin
            result_o <= result_next;
         end
      end
   end

endmodule
